// File: rtl/io_sampler.sv
// io_sampler: brings N_BIT asynchronous single-bit inputs and N_WORD parallel
// words into the CLK domain.
// Bit path: two-flop synchroniser, then a tick-based debounce, then registered
// rise/fall pulses and sticky "edge seen" flags.
// Word path: either a transparent per-cycle register or a snapshot taken on
// demand, with a per-word change pulse.
module io_sampler #(
  parameter int N_BIT  = 8,
  parameter int N_WORD = 4,
  parameter int WORD_W = 16,
  parameter int DB_CNT = 4,
  parameter int DB_W   = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     TICK,
  input  logic [N_BIT-1:0]         IN_BIT,
  input  logic [N_BIT-1:0]         EVT_CLR,
  input  logic [N_WORD*WORD_W-1:0] IN_WORD,
  input  logic                     MODE,
  input  logic                     SNAP,
  output logic [N_BIT-1:0]         OUT_BIT,
  output logic [N_BIT-1:0]         OUT_RISE,
  output logic [N_BIT-1:0]         OUT_FALL,
  output logic [N_BIT-1:0]         EVT_STICKY,
  output logic [N_WORD*WORD_W-1:0] OUT_WORD,
  output logic [N_WORD-1:0]        WORD_CHG,
  output logic                     SNAP_DONE
);

  // Synchroniser stages; r_s2 is the only bit-path consumer of IN_BIT.
  logic [N_BIT-1:0]  r_s1;
  logic [N_BIT-1:0]  r_s2;

  // Per-channel results gathered from the generate blocks.
  logic [N_BIT-1:0]  w_lvl;
  logic [N_BIT-1:0]  w_rise;
  logic [N_BIT-1:0]  w_fall;
  logic [N_BIT-1:0]  w_sticky;
  logic [N_WORD-1:0] w_chg;

  // Word capture enable: always in transparent mode, on SNAP in snapshot mode.
  logic w_cap;
  logic r_snap_done;

  assign w_cap = ~MODE | SNAP;

  // Two-flop synchroniser for all bit channels.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= IN_BIT;
      r_s2 <= r_s1;
    end
  end

  // ---------------------------------------------------------------------------
  // Bit channels
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_BIT; gi++) begin : g_bit
    logic r_lvl;
    logic r_rise;
    logic r_fall;
    logic r_sticky;

    if (DB_CNT == 0) begin : g_nodb
      // No debounce: follow the synchronised level every cycle, pulse on change.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_lvl  <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
        end else begin
          r_lvl  <= r_s2[gi];
          r_rise <= r_s2[gi] & ~r_lvl;
          r_fall <= ~r_s2[gi] & r_lvl;
        end
      end
    end else begin : g_db
      logic [DB_W-1:0] r_cnt;

      // Debounce: count TICKs while the synchronised level disagrees with the
      // accepted level; any agreement (glitch over) restarts the count at 0.
      always_ff @(posedge CLK) begin
        if (RST) begin
          r_lvl  <= 1'b0;
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          r_cnt  <= '0;
        end else begin
          r_rise <= 1'b0;
          r_fall <= 1'b0;
          if (r_s2[gi] == r_lvl) begin
            r_cnt <= '0;
          end else if (TICK) begin
            if (r_cnt == DB_W'(DB_CNT - 1)) begin
              r_lvl  <= r_s2[gi];
              r_cnt  <= '0;
              r_rise <= r_s2[gi];
              r_fall <= ~r_s2[gi];
            end else begin
              r_cnt <= r_cnt + DB_W'(1);
            end
          end
        end
      end
    end

    // Sticky flag follows the registered pulses one cycle later; a pulse
    // arriving together with a clear request keeps the flag set.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_sticky <= 1'b0;
      end else if (r_rise | r_fall) begin
        r_sticky <= 1'b1;
      end else if (EVT_CLR[gi]) begin
        r_sticky <= 1'b0;
      end
    end

    assign w_lvl[gi]    = r_lvl;
    assign w_rise[gi]   = r_rise;
    assign w_fall[gi]   = r_fall;
    assign w_sticky[gi] = r_sticky;
  end

  // ---------------------------------------------------------------------------
  // Word channels
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < N_WORD; gi++) begin : g_word
    logic [WORD_W-1:0] r_word;
    logic              r_chg;

    // Capture the word when enabled and flag it if the captured value differs
    // from what was previously presented on OUT_WORD.
    always_ff @(posedge CLK) begin
      if (RST) begin
        r_word <= '0;
        r_chg  <= 1'b0;
      end else begin
        r_chg <= 1'b0;
        if (w_cap) begin
          r_word <= IN_WORD[gi*WORD_W +: WORD_W];
          r_chg  <= (IN_WORD[gi*WORD_W +: WORD_W] != r_word);
        end
      end
    end

    assign OUT_WORD[gi*WORD_W +: WORD_W] = r_word;
    assign w_chg[gi]                     = r_chg;
  end

  // Snapshot acknowledge appears together with the captured words.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_snap_done <= 1'b0;
    end else begin
      r_snap_done <= MODE & SNAP;
    end
  end

  assign OUT_BIT    = w_lvl;
  assign OUT_RISE   = w_rise;
  assign OUT_FALL   = w_fall;
  assign EVT_STICKY = w_sticky;
  assign WORD_CHG   = w_chg;
  assign SNAP_DONE  = r_snap_done;

endmodule

// File: tb/tb_io_sampler.sv
// tb_io_sampler: self-checking bench for io_sampler.
// Instance u_dut uses DB_CNT=4 (debounced bit path, word path);
// instance u_nodb uses DB_CNT=0 (direct bit path).
module tb_io_sampler;

  logic        clk;
  logic        rst;
  logic        tick;
  logic [7:0]  in_bit;
  logic [7:0]  in_bit_nd;
  logic [7:0]  evt_clr;
  logic [63:0] in_word;
  logic        mode;
  logic        snap;

  logic [7:0]  out_bit, out_rise, out_fall, sticky;
  logic [63:0] out_word;
  logic [3:0]  word_chg;
  logic        snap_done;

  logic [7:0]  nd_bit, nd_rise, nd_fall, nd_sticky;
  logic [63:0] nd_word;
  logic [3:0]  nd_chg;
  logic        nd_done;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int rise_cnt [8];
  int fall_cnt [8];
  int exp_rise [8];
  int exp_fall [8];

  typedef struct {
    int          cyc;
    logic [63:0] word;
    logic [3:0]  chg;
    logic        done;
  } wexp_t;

  typedef struct {
    int         cyc;
    logic [7:0] lvl;
    logic [7:0] rise;
    logic [7:0] fall;
  } bexp_t;

  wexp_t wq[$];
  bexp_t bq[$];

  logic [63:0] exp_out;
  logic [7:0]  prev_nd;

  io_sampler #(.N_BIT(8), .N_WORD(4), .WORD_W(16), .DB_CNT(4), .DB_W(8)) u_dut (
    .CLK(clk), .RST(rst), .TICK(tick), .IN_BIT(in_bit), .EVT_CLR(evt_clr),
    .IN_WORD(in_word), .MODE(mode), .SNAP(snap),
    .OUT_BIT(out_bit), .OUT_RISE(out_rise), .OUT_FALL(out_fall),
    .EVT_STICKY(sticky), .OUT_WORD(out_word), .WORD_CHG(word_chg),
    .SNAP_DONE(snap_done)
  );

  io_sampler #(.N_BIT(8), .N_WORD(4), .WORD_W(16), .DB_CNT(0), .DB_W(8)) u_nodb (
    .CLK(clk), .RST(rst), .TICK(tick), .IN_BIT(in_bit_nd), .EVT_CLR(8'h00),
    .IN_WORD(in_word), .MODE(mode), .SNAP(snap),
    .OUT_BIT(nd_bit), .OUT_RISE(nd_rise), .OUT_FALL(nd_fall),
    .EVT_STICKY(nd_sticky), .OUT_WORD(nd_word), .WORD_CHG(nd_chg),
    .SNAP_DONE(nd_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cyc %0d)", tag, got, exp, cyc);
  endtask

  // Monitor: count debounced pulses and pop scoreboard entries when due.
  always @(negedge clk) begin
    wexp_t we;
    bexp_t be;
    if (!rst) begin
      for (int i = 0; i < 8; i++) begin
        if (out_rise[i]) begin
          rise_cnt[i]++;
          $display("bit %0d rise at cyc %0d", i, cyc);
          chk("rise_level", 64'(out_bit[i]), 64'h1);
        end
        if (out_fall[i]) begin
          fall_cnt[i]++;
          $display("bit %0d fall at cyc %0d", i, cyc);
          chk("fall_level", 64'(out_bit[i]), 64'h0);
        end
      end
    end
    if (wq.size() > 0 && wq[0].cyc == cyc) begin
      we = wq.pop_front();
      $display("word cyc=%0d out=%h chg=%b done=%b", cyc, out_word, word_chg, snap_done);
      chk("word_out", out_word, we.word);
      chk("word_chg", 64'(word_chg), 64'(we.chg));
      chk("snap_done", 64'(snap_done), 64'(we.done));
    end
    if (bq.size() > 0 && bq[0].cyc == cyc) begin
      be = bq.pop_front();
      $display("nodb cyc=%0d lvl=%h rise=%h fall=%h", cyc, nd_bit, nd_rise, nd_fall);
      chk("nodb_lvl", 64'(nd_bit), 64'(be.lvl));
      chk("nodb_rise", 64'(nd_rise), 64'(be.rise));
      chk("nodb_fall", 64'(nd_fall), 64'(be.fall));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Change the bit inputs and give the synchroniser time to settle.
  task automatic set_bits(input logic [7:0] v);
    in_bit = v;
    repeat (3) step();
  endtask

  // One TICK period of 10 cycles; clr is driven in the cycle right after the
  // TICK edge, which is where an accepted edge pulse is visible.
  task automatic tick_once(input logic [7:0] clr);
    tick = 1'b1;
    step();
    tick = 1'b0;
    if (clr != 8'h00) chk("fall_with_clr", 64'(out_fall), 64'(clr));
    evt_clr = clr;
    step();
    evt_clr = 8'h00;
    repeat (8) step();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick_once(8'h00);
  endtask

  task automatic chk_counts(input string tag);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_rise"}, 64'(rise_cnt[i]), 64'(exp_rise[i]));
      chk({tag, "_fall"}, 64'(fall_cnt[i]), 64'(exp_fall[i]));
    end
  endtask

  task automatic clear_sticky(input logic [7:0] m);
    evt_clr = m;
    step();
    evt_clr = 8'h00;
  endtask

  // Drive one word-path cycle and predict the outputs one cycle later.
  task automatic wdrive(input logic m, input logic s, input logic [63:0] w);
    logic        cap;
    logic [3:0]  chg;
    logic [63:0] nxt;
    mode    = m;
    snap    = s;
    in_word = w;
    cap = !m || s;
    nxt = cap ? w : exp_out;
    for (int j = 0; j < 4; j++) chg[j] = cap && (w[j*16 +: 16] != exp_out[j*16 +: 16]);
    wq.push_back('{cyc + 1, nxt, chg, m && s});
    exp_out = nxt;
    step();
  endtask

  // Drive the non-debounced instance; output expected two edges after capture.
  task automatic bdrive(input logic [7:0] v);
    in_bit_nd = v;
    bq.push_back('{cyc + 3, v, v & ~prev_nd, ~v & prev_nd});
    prev_nd = v;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit (cyc %0d)", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 8; i++) begin
      rise_cnt[i] = 0; fall_cnt[i] = 0; exp_rise[i] = 0; exp_fall[i] = 0;
    end
    rst       = 1'b1;
    tick      = 1'b0;
    in_bit    = 8'hFF;
    in_bit_nd = 8'h00;
    evt_clr   = 8'h00;
    in_word   = 64'h4444_3333_2222_1111;
    mode      = 1'b0;
    snap      = 1'b0;
    prev_nd   = 8'h00;
    exp_out   = 64'h4444_3333_2222_1111;

    // Reset held for 3 cycles with active inputs: everything stays 0.
    repeat (3) step();
    chk("rst_out_bit", 64'(out_bit), 64'h0);
    chk("rst_rise", 64'(out_rise), 64'h0);
    chk("rst_fall", 64'(out_fall), 64'h0);
    chk("rst_sticky", 64'(sticky), 64'h0);
    chk("rst_word", out_word, 64'h0);
    chk("rst_chg", 64'(word_chg), 64'h0);
    chk("rst_done", 64'(snap_done), 64'h0);
    chk("rst_nodb_all", {nd_bit, nd_rise, nd_fall, nd_sticky, 32'h0},
        64'h0);
    chk("rst_nodb_word", {nd_word[59:0], nd_chg}, {60'h0, 4'h0} | 64'(nd_done));
    rst = 1'b0;

    // Input high out of reset: accepted exactly on the 4th TICK.
    repeat (3) step();
    ticks(3);
    chk("pre_accept_bits", 64'(out_bit), 64'h00);
    ticks(1);
    chk("accept_bits", 64'(out_bit), 64'hFF);
    for (int i = 0; i < 8; i++) exp_rise[i]++;
    chk_counts("after_reset");
    chk("sticky_all", 64'(sticky), 64'hFF);
    clear_sticky(8'hFF);
    chk("sticky_cleared", 64'(sticky), 64'h00);

    // Return all bits low.
    set_bits(8'h00);
    ticks(4);
    for (int i = 0; i < 8; i++) exp_fall[i]++;
    chk("all_low", 64'(out_bit), 64'h00);
    chk_counts("all_low");
    clear_sticky(8'hFF);

    // Glitch on bit 0 lasting 3 TICKs is rejected and the count restarts.
    set_bits(8'h01);
    ticks(3);
    set_bits(8'h00);
    ticks(2);
    chk("glitch_bit", 64'(out_bit), 64'h00);
    chk("glitch_sticky", 64'(sticky), 64'h00);
    chk_counts("glitch");
    set_bits(8'h01);
    ticks(3);
    chk("cnt_restart", 64'(out_bit), 64'h00);
    ticks(1);
    chk("bit0_accept", 64'(out_bit), 64'h01);
    exp_rise[0]++;
    set_bits(8'h00);
    ticks(4);
    exp_fall[0]++;
    chk_counts("bit0");
    clear_sticky(8'hFF);

    // Bit 3 rise, then fall with a clear request in the pulse cycle.
    set_bits(8'h08);
    ticks(4);
    exp_rise[3]++;
    chk("bit3_high", 64'(out_bit), 64'h08);
    chk("bit3_sticky", 64'(sticky), 64'h08);
    clear_sticky(8'h08);
    chk("bit3_sticky_clr", 64'(sticky), 64'h00);
    set_bits(8'h00);
    ticks(3);
    tick_once(8'h08);
    exp_fall[3]++;
    chk("bit3_low", 64'(out_bit), 64'h00);
    chk("race_set_wins", 64'(sticky), 64'h08);
    clear_sticky(8'h08);
    chk("clr_alone", 64'(sticky), 64'h00);
    chk_counts("bit3");

    // Word path: transparent, then snapshot mode.
    wdrive(1'b0, 1'b0, 64'h4444_1234_2222_1111);
    wdrive(1'b0, 1'b1, 64'h4444_1234_2222_1111);
    wdrive(1'b1, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
    wdrive(1'b1, 1'b0, 64'h5555_6666_7777_8888);
    wdrive(1'b1, 1'b1, 64'hAAAA_1234_CCCC_1111);
    wdrive(1'b1, 1'b1, 64'hAAAA_1234_CCCC_1112);
    wdrive(1'b1, 1'b1, 64'hAAAA_1234_CCCC_1112);
    wdrive(1'b1, 1'b0, 64'h0000_0000_0000_0000);
    wdrive(1'b0, 1'b0, 64'h0000_0000_0000_0000);
    for (int k = 0; k < 8; k++)
      wdrive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             {16'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 1)), 16'($urandom)});
    mode = 1'b0;
    snap = 1'b0;
    repeat (2) step();
    chk("word_q_drained", 64'(wq.size()), 64'h0);

    // Non-debounced instance: fixed and random toggles.
    bdrive(8'h01);
    bdrive(8'h01);
    bdrive(8'h00);
    bdrive(8'hF0);
    bdrive(8'h0F);
    for (int k = 0; k < 8; k++) bdrive(8'($urandom));
    bdrive(8'h00);
    repeat (4) step();
    chk("nodb_q_drained", 64'(bq.size()), 64'h0);

    // Debounced path saw no activity during the word/nodb phases.
    chk_counts("final");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
